// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and width constants shared by the ALU decoder and alu_seq.
package alu_pkg;
    localparam int XLEN_DEF = 32;
    localparam int SHAMT_W  = $clog2(XLEN_DEF);
    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLT  = 4'd5,
        SLTU = 4'd6,
        SLL  = 4'd7,
        SRL  = 4'd8,
        SRA  = 4'd9
    } alu_op_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between the control FSM and alu_seq.
interface alu_seq_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ALUControl;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUResult;
    logic            Zero;
    modport master (output in_valid, ALUControl, SrcA, SrcB, out_ready,
                    input  in_ready, out_valid, ALUResult, Zero);
    modport slave  (input  in_valid, ALUControl, SrcA, SrcB, out_ready,
                    output in_ready, out_valid, ALUResult, Zero);
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU ops; shifts and undefined codes yield 0.
module alu_core import alu_pkg::*; #(parameter int XLEN = 32) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            SLT:     y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            SLTU:    y = {{(XLEN-1){1'b0}}, a < b};
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute ALU; single-cycle ops via alu_core, shifts via a 1-bit/cycle serial shifter.
module alu_seq import alu_pkg::*; #(parameter int XLEN = 32) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    alu_state_t      state, state_n;
    logic [XLEN-1:0] res, res_n, core_y;
    logic [SW-1:0]   cnt, cnt_n, shamt;
    logic [3:0]      op, op_n;
    logic            is_shift;
    alu_core #(.XLEN(XLEN)) u_core (.op(bus.ALUControl), .a(bus.SrcA), .b(bus.SrcB), .y(core_y));
    assign shamt    = bus.SrcB[SW-1:0];
    assign is_shift = bus.ALUControl inside {SLL, SRL, SRA};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            res   <= '0;
            cnt   <= '0;
            op    <= '0;
        end else begin
            state <= state_n;
            res   <= res_n;
            cnt   <= cnt_n;
            op    <= op_n;
        end
    end
    // SRA fill uses res MSB: it still holds the captured SrcA sign bit throughout the shift
    always_comb begin
        state_n = state;
        res_n   = res;
        cnt_n   = cnt;
        op_n    = op;
        case (state)
            IDLE: if (bus.in_valid) begin
                op_n = bus.ALUControl;
                if (is_shift && shamt != '0) begin
                    res_n   = bus.SrcA;
                    cnt_n   = shamt;
                    state_n = SHIFT;
                end else begin
                    res_n   = is_shift ? bus.SrcA : core_y;
                    state_n = DONE;
                end
            end
            SHIFT: begin
                res_n   = (op == SLL) ? {res[XLEN-2:0], 1'b0}
                                      : {(op == SRA) ? res[XLEN-1] : 1'b0, res[XLEN-1:1]};
                cnt_n   = cnt - 1'b1;
                state_n = (cnt == 1) ? DONE : SHIFT;
            end
            DONE:    state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.ALUResult = res;
    assign bus.Zero      = (res == '0);
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against a plain-arithmetic reference model.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    alu_seq_if #(.XLEN(32)) bus ();
    alu_seq #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh = int'(b[4:0]);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: return (a < b) ? 32'd1 : 32'd0;
            7: return a << sh;
            8: return a >> sh;
            9: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input int op, input logic [31:0] b);
        return (op >= 7 && op <= 9 && b[4:0] != 0) ? int'(b[4:0]) + 1 : 1;
    endfunction

    // Issues one op and waits for out_valid; leaves the result pending (out_ready low).
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic z, output logic irdy);
        int t = 0;
        while (!bus.in_ready && t < 100) begin @(posedge clk); #1; t++; end
        bus.ALUControl = 4'(op);
        bus.SrcA = a;
        bus.SrcB = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.ALUControl = 4'($urandom);
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = bus.ALUResult;
        z = bus.Zero;
        irdy = bus.in_ready;
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        if (bus.ALUResult !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.ALUResult); end
        if (bus.Zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", bus.Zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int          ops[8]  = '{0, 1, 5, 6, 9, 8, 7, 12};
        logic [31:0] as[8]   = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [31:0] bs[8]   = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd31, 32'd31, 32'h0000_0020, 32'h1357_9BDF};
        logic [31:0] exp[8]  = '{32'h8000_0000, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 32'd0};
        int          elat[8] = '{1, 1, 1, 1, 32, 32, 1, 1};
        int lat;
        logic [31:0] r;
        logic z, irdy;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], lat, r, z, irdy);
            total += 5;
            if (lat !== elat[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, elat[i]); end
            if (r !== exp[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, r, exp[i]); end
            if (z !== (exp[i] == 0)) begin bad++; $display("FAIL dir%0d_zero got=%b want=%b", i, z, exp[i] == 0); end
            if (irdy !== 1'b0) begin bad++; $display("FAIL dir%0d_in_ready got=%b want=0", i, irdy); end
            handoff();
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_drop got=%b want=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_random();
        int lat, op;
        logic [31:0] a, b, r;
        logic z, irdy;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 15);
            a = $urandom;
            b = $urandom;
            run_op(op, a, b, lat, r, z, irdy);
            total += 3;
            if (lat !== ref_lat(op, b)) begin bad++; $display("FAIL rnd%0d_latency op=%0d got=%0d want=%0d", i, op, lat, ref_lat(op, b)); end
            if (r !== ref_alu(op, a, b)) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, r, ref_alu(op, a, b)); end
            if (z !== (ref_alu(op, a, b) == 0)) begin bad++; $display("FAIL rnd%0d_zero got=%b", i, z); end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] r, want;
        logic z, irdy;
        want = ref_alu(9, 32'hF0F0_0000, 32'd3);
        run_op(9, 32'hF0F0_0000, 32'd3, lat, r, z, irdy);
        total++;
        if (r !== want) begin bad++; $display("FAIL bp_result got=%h want=%h", r, want); end
        for (int i = 0; i < 5; i++) begin
            bus.SrcA = $urandom;
            bus.SrcB = $urandom;
            bus.ALUControl = 4'd0;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            total += 3;
            if (bus.ALUResult !== want) begin bad++; $display("FAIL bp%0d_hold got=%h want=%h", i, bus.ALUResult, want); end
            if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_in_ready got=%b want=0", i, bus.in_ready); end
            if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_out_valid got=%b want=1", i, bus.out_valid); end
        end
        bus.in_valid = 1'b0;
        handoff();
        total += 2;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        int op;
        logic [31:0] a, b;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(0, 6);
            a = $urandom;
            b = $urandom;
            total += 3;
            if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_in_ready got=%b want=1", i, bus.in_ready); end
            bus.ALUControl = 4'(op);
            bus.SrcA = a;
            bus.SrcB = b;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.ALUResult !== ref_alu(op, a, b)) begin
                bad++;
                $display("FAIL b2b%0d_result valid=%b got=%h want=%h", i, bus.out_valid, bus.ALUResult, ref_alu(op, a, b));
            end
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b%0d_drop got=%b want=0", i, bus.out_valid); end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        int lat, seen = 0;
        logic [31:0] r;
        logic z, irdy;
        bus.ALUControl = 4'd8;
        bus.SrcA = 32'hCAFE_F00D;
        bus.SrcB = 32'd20;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b want=0", bus.out_valid); end
        if (bus.ALUResult !== 32'd0) begin bad++; $display("FAIL mid_rst_result got=%h want=0", bus.ALUResult); end
        if (bus.Zero !== 1'b1) begin bad++; $display("FAIL mid_rst_zero got=%b want=1", bus.Zero); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL mid_rst_discard got=%0d valid cycles want=0", seen); end
        run_op(0, 32'd100, 32'd23, lat, r, z, irdy);
        total += 2;
        if (r !== 32'd123) begin bad++; $display("FAIL post_rst_result got=%h want=%h", r, 32'd123); end
        if (lat !== 1) begin bad++; $display("FAIL post_rst_latency got=%0d want=1", lat); end
        handoff();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.ALUControl = '0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
